// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants: request op codes, R-type funct values,
// I-type opcodes and the load-session state encoding.
package mips_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_SLT  = 4'd4,
    OP_ADDI = 4'd5,
    OP_SLTI = 4'd6,
    OP_ANDI = 4'd7,
    OP_ORI  = 4'd8,
    OP_LW   = 4'd9,
    OP_SW   = 4'd10
  } op_e;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_SLTI  = 6'h0A;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count. A push on a full FIFO is taken
// only when a pop happens on the same edge.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Data storage; contents are only meaningful while occupied
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mips_instr_encoder.sv
// Program-load encoder: assembles symbolic requests into MIPS R/I-type words,
// buffers them and writes them to consecutive instruction-memory addresses.
module mips_instr_encoder
  import mips_pkg::*;
#(
  parameter int ADDR_W     = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [4:0]        req_rs,
  input  logic [4:0]        req_rt,
  input  logic [4:0]        req_rd,
  input  logic [15:0]       req_imm,
  input  logic              req_last,
  output logic              imem_we,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err_op,
  output logic              err_full,
  output logic [ADDR_W:0]   word_count
);

  localparam int CW = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W+1:0] CAPACITY = (ADDR_W+2)'(2**ADDR_W);

  logic [1:0]        state;
  logic [ADDR_W-1:0] addr;
  logic [CW:0]       fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic [31:0]       fifo_dout;
  logic [ADDR_W+1:0] reserved;
  logic              accept;
  logic              write;
  logic              enc_valid;
  logic [31:0]       enc_word;

  // Words already written plus words still queued; caps how many more we take
  assign reserved   = (ADDR_W+2)'(word_count) + (ADDR_W+2)'(fifo_count);
  assign req_ready  = (state == ST_LOAD) && !fifo_full && (reserved < CAPACITY);
  assign accept     = req_valid && req_ready;
  assign write      = !fifo_empty && imem_ready;
  assign imem_we    = !fifo_empty;
  assign imem_wdata = fifo_empty ? 32'h0 : fifo_dout;
  assign imem_addr  = addr;
  assign busy       = (state != ST_IDLE);
  assign done       = (state == ST_DONE);

  // Encode the presented request; unsupported ops yield enc_valid=0
  always_comb begin
    enc_valid = 1'b1;
    enc_word  = 32'h0;
    case (req_op)
      OP_ADD:  enc_word = {OPC_RTYPE, req_rs, req_rt, req_rd, 5'b0, FUNCT_ADD};
      OP_SUB:  enc_word = {OPC_RTYPE, req_rs, req_rt, req_rd, 5'b0, FUNCT_SUB};
      OP_AND:  enc_word = {OPC_RTYPE, req_rs, req_rt, req_rd, 5'b0, FUNCT_AND};
      OP_OR:   enc_word = {OPC_RTYPE, req_rs, req_rt, req_rd, 5'b0, FUNCT_OR};
      OP_SLT:  enc_word = {OPC_RTYPE, req_rs, req_rt, req_rd, 5'b0, FUNCT_SLT};
      OP_ADDI: enc_word = {OPC_ADDI, req_rs, req_rt, req_imm};
      OP_SLTI: enc_word = {OPC_SLTI, req_rs, req_rt, req_imm};
      OP_ANDI: enc_word = {OPC_ANDI, req_rs, req_rt, req_imm};
      OP_ORI:  enc_word = {OPC_ORI,  req_rs, req_rt, req_imm};
      OP_LW:   enc_word = {OPC_LW,   req_rs, req_rt, req_imm};
      OP_SW:   enc_word = {OPC_SW,   req_rs, req_rt, req_imm};
      default: enc_valid = 1'b0;
    endcase
  end

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept && enc_valid),
    .din   (enc_word),
    .pop   (write),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Session FSM, write address, word counter and sticky error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      addr       <= '0;
      word_count <= '0;
      err_op     <= 1'b0;
      err_full   <= 1'b0;
    end else begin
      if (write) begin
        word_count <= word_count + 1'b1;
        if (addr != '1) addr <= addr + 1'b1;
      end
      if (accept && !enc_valid) err_op <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state      <= ST_LOAD;
            addr       <= '0;
            word_count <= '0;
            err_op     <= 1'b0;
            err_full   <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (accept && req_last) begin
            state <= ST_FLUSH;
          end else if (reserved == CAPACITY) begin
            state    <= ST_FLUSH;
            err_full <= 1'b1;
          end
        end
        ST_FLUSH: begin
          if (fifo_empty) state <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Self-checking bench for mips_instr_encoder: table of single-word sessions,
// hand sequences for backpressure/reset/errors/capacity, and random sessions
// compared against an arithmetic encoding model.
module tb_mips_instr_encoder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start, req_valid, req_last;
  logic [3:0]  req_op;
  logic [4:0]  req_rs, req_rt, req_rd;
  logic [15:0] req_imm;
  logic        fixed_ready, rand_ready, rnd_bit;
  logic        imem_ready;
  assign imem_ready = rand_ready ? rnd_bit : fixed_ready;

  logic        req_ready, imem_we, busy, done, err_op, err_full;
  logic [5:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [6:0]  word_count;

  logic        s_start, s_req_valid, s_imem_ready;
  logic        s_req_ready, s_imem_we, s_busy, s_done, s_err_op, s_err_full;
  logic [1:0]  s_imem_addr;
  logic [31:0] s_imem_wdata;
  logic [2:0]  s_word_count;

  mips_instr_encoder dut (
    .clk(clk), .rst_n(rst_n), .start(start), .req_valid(req_valid),
    .req_ready(req_ready), .req_op(req_op), .req_rs(req_rs), .req_rt(req_rt),
    .req_rd(req_rd), .req_imm(req_imm), .req_last(req_last), .imem_we(imem_we),
    .imem_ready(imem_ready), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .done(done), .err_op(err_op), .err_full(err_full),
    .word_count(word_count)
  );

  mips_instr_encoder #(.ADDR_W(2), .FIFO_DEPTH(4)) dut_small (
    .clk(clk), .rst_n(rst_n), .start(s_start), .req_valid(s_req_valid),
    .req_ready(s_req_ready), .req_op(req_op), .req_rs(req_rs), .req_rt(req_rt),
    .req_rd(req_rd), .req_imm(req_imm), .req_last(req_last), .imem_we(s_imem_we),
    .imem_ready(s_imem_ready), .imem_addr(s_imem_addr), .imem_wdata(s_imem_wdata),
    .busy(s_busy), .done(s_done), .err_op(s_err_op), .err_full(s_err_full),
    .word_count(s_word_count)
  );

  int checks = 0;
  int failures = 0;

  // Random memory backpressure source
  always @(negedge clk) rnd_bit = 1'($urandom_range(0, 1));

  // Reference encoding: field values placed by multiplication, not bit slicing
  function automatic logic [32:0] model_encode(input int op, input int rs, input int rt,
                                               input int rd, input int imm);
    longint w;
    int funct;
    int opc;
    funct = 0;
    opc = 0;
    case (op)
      0: funct = 32;  1: funct = 34;  2: funct = 36;  3: funct = 37;  4: funct = 42;
      5: opc = 8;     6: opc = 10;    7: opc = 12;    8: opc = 13;
      9: opc = 35;    10: opc = 43;
      default: return 33'h0;
    endcase
    if (op <= 4)
      w = longint'(rs) * 2097152 + longint'(rt) * 65536 + longint'(rd) * 2048 + longint'(funct);
    else
      w = longint'(opc) * 67108864 + longint'(rs) * 2097152 + longint'(rt) * 65536 + longint'(imm);
    return {1'b1, w[31:0]};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
    end
  endtask

  // Write monitor / scoreboard for the main instance
  logic [31:0] exp_q[$];
  logic [31:0] log_data[64];
  int          log_addr[64];
  int          exp_addr, wr_count, acc_count;
  logic [32:0] enc;
  logic [31:0] exp_w;

  always @(negedge clk) begin
    #3;
    if (!rst_n) begin
      exp_q.delete();
      exp_addr = 0; wr_count = 0; acc_count = 0;
    end else begin
      if (start && !busy) begin
        exp_q.delete();
        exp_addr = 0; wr_count = 0; acc_count = 0;
      end
      if (imem_we && imem_ready) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("[TB] FAIL unexpected_write actual=%0h required=none", imem_wdata);
        end else begin
          exp_w = exp_q.pop_front();
          checkOutput("write_data", imem_wdata, exp_w);
          checkOutput("write_addr", imem_addr, exp_addr[5:0]);
        end
        if (wr_count < 64) begin
          log_data[wr_count] = imem_wdata;
          log_addr[wr_count] = int'(imem_addr);
        end
        exp_addr++;
        wr_count++;
      end
      if (req_valid && req_ready) begin
        acc_count++;
        enc = model_encode(int'(req_op), int'(req_rs), int'(req_rt), int'(req_rd), int'(req_imm));
        if (enc[32]) exp_q.push_back(enc[31:0]);
      end
    end
  end

  // All tasks below begin and end on a falling clock edge
  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic applyStimulus(input int op, input int rs, input int rt, input int rd,
                               input int imm, input bit last);
    int n;
    req_valid = 1'b1;
    req_op = op[3:0]; req_rs = rs[4:0]; req_rt = rt[4:0]; req_rd = rd[4:0];
    req_imm = imm[15:0]; req_last = last;
    #3;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk); #3; n++;
    end
    checkOutput("req_accept", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    req_last = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    bit seen;
    n = 0; seen = 0;
    while (!seen && n < budget) begin
      #3;
      if (done) seen = 1;
      @(negedge clk);
      n++;
    end
    checkOutput("done_seen", seen, 1);
    #3;
    checkOutput("done_one_cycle", done, 0);
    checkOutput("idle_after_done", busy, 0);
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_req_ready"}, req_ready, 0);
    checkOutput({tag, "_imem_we"}, imem_we, 0);
    checkOutput({tag, "_imem_addr"}, imem_addr, 0);
    checkOutput({tag, "_imem_wdata"}, imem_wdata, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_err_op"}, err_op, 0);
    checkOutput({tag, "_err_full"}, err_full, 0);
    checkOutput({tag, "_word_count"}, word_count, 0);
  endtask

  // Runs one session on the ADDR_W=2 instance, presenting requests every cycle
  task automatic small_run(input bit with_last, input int exp_acc, input bit exp_full);
    int sacc, swr, sdone;
    sacc = 0; swr = 0; sdone = 0;
    req_op = 4'd5; req_rs = 5'd1; req_rt = 5'd2; req_rd = 5'd0; req_imm = 16'd7;
    req_last = 1'b0;
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    s_req_valid = 1'b1;
    for (int c = 0; c < 30; c++) begin
      req_last = with_last && (sacc == 3);
      #3;
      if (s_req_valid && s_req_ready) sacc++;
      if (s_imem_we && s_imem_ready) begin
        checkOutput("small_addr", s_imem_addr, swr[1:0]);
        checkOutput("small_data", s_imem_wdata, 32'h20220007);
        swr++;
      end
      if (s_done) sdone++;
      @(negedge clk);
    end
    s_req_valid = 1'b0;
    req_last = 1'b0;
    checkOutput("small_accepted", sacc, exp_acc);
    checkOutput("small_writes", swr, exp_acc);
    checkOutput("small_done_pulses", sdone, 1);
    checkOutput("small_err_full", s_err_full, exp_full);
    checkOutput("small_err_op", s_err_op, 0);
    checkOutput("small_word_count", s_word_count, exp_acc);
    checkOutput("small_busy", s_busy, 0);
  endtask

  typedef struct {
    int op; int rs; int rt; int rd; int imm;
    bit valid;
    logic [31:0] word;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n, nvalid, op;
    bit inv;

    vecs[0]  = '{0, 1, 2, 3, 0, 1'b1, 32'h00221820};
    vecs[1]  = '{1, 4, 5, 6, 0, 1'b1, 32'h00853022};
    vecs[2]  = '{2, 7, 8, 9, 0, 1'b1, 32'h00E84824};
    vecs[3]  = '{3, 10, 11, 12, 0, 1'b1, 32'h014B6025};
    vecs[4]  = '{4, 13, 14, 15, 16'hFFFF, 1'b1, 32'h01AE782A};
    vecs[5]  = '{5, 1, 2, 31, 16'hFFFF, 1'b1, 32'h2022FFFF};
    vecs[6]  = '{6, 3, 4, 0, 16'h0010, 1'b1, 32'h28640010};
    vecs[7]  = '{7, 5, 6, 0, 16'h00FF, 1'b1, 32'h30A600FF};
    vecs[8]  = '{8, 31, 31, 0, 16'h1234, 1'b1, 32'h37FF1234};
    vecs[9]  = '{9, 29, 8, 0, 4, 1'b1, 32'h8FA80004};
    vecs[10] = '{10, 29, 9, 0, 8, 1'b1, 32'hAFA90008};
    vecs[11] = '{12, 1, 1, 1, 1, 1'b0, 32'h0};

    start = 0; req_valid = 0; req_last = 0; req_op = 0;
    req_rs = 0; req_rt = 0; req_rd = 0; req_imm = 0;
    fixed_ready = 1; rand_ready = 0;
    s_start = 0; s_req_valid = 0; s_imem_ready = 1;

    repeat (2) @(negedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] table of single-word sessions");
    for (int i = 0; i < 12; i++) begin
      do_start();
      applyStimulus(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].imm, 1'b1);
      if (vecs[i].valid) begin
        #3;
        checkOutput("we_latency", imem_we, 1);
        @(negedge clk);
      end
      wait_done(50);
      if (vecs[i].valid) checkOutput("tbl_word", log_data[0], vecs[i].word);
      checkOutput("tbl_word_count", word_count, vecs[i].valid ? 1 : 0);
      checkOutput("tbl_err_op", err_op, vecs[i].valid ? 0 : 1);
      checkOutput("tbl_err_full", err_full, 0);
    end

    $display("[TB] lw/sw pair");
    do_start();
    applyStimulus(9, 29, 8, 0, 4, 1'b0);
    applyStimulus(10, 29, 9, 0, 8, 1'b1);
    wait_done(50);
    checkOutput("pair_w0", log_data[0], 32'h8FA80004);
    checkOutput("pair_w1", log_data[1], 32'hAFA90008);
    checkOutput("pair_a1", log_addr[1], 1);
    checkOutput("pair_count", word_count, 2);

    $display("[TB] backpressure");
    fixed_ready = 0;
    do_start();
    for (int i = 0; i < 4; i++) applyStimulus(i, i + 1, i + 2, i + 3, 100 + i, 1'b0);
    #3;
    checkOutput("bp_ready_low", req_ready, 0);
    checkOutput("bp_accepted", acc_count, 4);
    checkOutput("bp_no_write", wr_count, 0);
    checkOutput("bp_we_held", imem_we, 1);
    @(negedge clk);
    repeat (4) @(negedge clk);
    fixed_ready = 1;
    applyStimulus(9, 2, 3, 0, 16'h00F0, 1'b0);
    applyStimulus(10, 4, 5, 0, 16'h0F00, 1'b1);
    wait_done(100);
    checkOutput("bp_writes", wr_count, 6);
    checkOutput("bp_word_count", word_count, 6);
    for (int i = 0; i < 6; i++) checkOutput("bp_addr_order", log_addr[i], i);

    $display("[TB] unsupported op between addi");
    do_start();
    applyStimulus(5, 1, 2, 0, 100, 1'b0);
    applyStimulus(15, 3, 3, 3, 3, 1'b0);
    applyStimulus(5, 3, 4, 0, 200, 1'b1);
    wait_done(50);
    checkOutput("bad_err_op", err_op, 1);
    checkOutput("bad_word_count", word_count, 2);
    checkOutput("bad_w0", log_data[0], 32'h20220064);
    checkOutput("bad_w1", log_data[1], 32'h206400C8);
    checkOutput("bad_a1", log_addr[1], 1);

    $display("[TB] reset during write");
    fixed_ready = 0;
    do_start();
    applyStimulus(0, 1, 2, 3, 0, 1'b0);
    applyStimulus(1, 4, 5, 6, 0, 1'b0);
    #1;
    checkOutput("rst_we_before", imem_we, 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    fixed_ready = 1;
    @(negedge clk);
    do_start();
    applyStimulus(3, 10, 11, 12, 0, 1'b1);
    wait_done(50);
    checkOutput("restart_addr", log_addr[0], 0);
    checkOutput("restart_word", log_data[0], 32'h014B6025);
    checkOutput("restart_count", word_count, 1);

    $display("[TB] random sessions");
    rand_ready = 1;
    for (int s = 0; s < 6; s++) begin
      n = $urandom_range(1, 10);
      nvalid = 0; inv = 0;
      do_start();
      for (int i = 0; i < n; i++) begin
        op = ($urandom_range(0, 7) == 0) ? $urandom_range(11, 15) : $urandom_range(0, 10);
        if (op > 10) inv = 1; else nvalid++;
        applyStimulus(op, $urandom_range(0, 31), $urandom_range(0, 31),
                      $urandom_range(0, 31), $urandom_range(0, 65535), i == n - 1);
      end
      wait_done(200);
      checkOutput("rnd_word_count", word_count, nvalid);
      checkOutput("rnd_writes", wr_count, nvalid);
      checkOutput("rnd_err_op", err_op, inv);
      checkOutput("rnd_err_full", err_full, 0);
    end
    rand_ready = 0;

    $display("[TB] capacity limit on ADDR_W=2 instance");
    small_run(1'b0, 4, 1'b1);
    small_run(1'b1, 4, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
